multicycle_ctrl: RTL

- Sequencing FSM for the multi-cycle RV32I core: steps the shared datapath (IR, PC, ALU, comparator, register file, single memory port) through fetch/decode/execute/memory/writeback for one instruction at a time.
- Produces all datapath enables and selects, drives the memory request handshake, raises traps and counts retired instructions.
- Sits beside the datapath; the datapath owns the IR, PC and register file and feeds decoded fields back to this block.

---
 rtl/multicycle_ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_decode.sv | 57 +++++
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared RV32I types for the multi-cycle controller
package multicycle_ctrl_pkg;

  typedef enum logic [6:0] {
    OP_LOAD     = 7'b0000011,
    OP_MISC_MEM = 7'b0001111,
    OP_IMM      = 7'b0010011,
    OP_AUIPC    = 7'b0010111,
    OP_STORE    = 7'b0100011,
    OP_OP       = 7'b0110011,
    OP_LUI      = 7'b0110111,
    OP_BRANCH   = 7'b1100011,
    OP_JALR     = 7'b1100111,
    OP_JAL      = 7'b1101111,
    OP_SYSTEM   = 7'b1110011
  } opcode_t;

  // Encoded as {funct7[5], funct3} so OP/OP_IMM map straight through.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_LTU = 3'b110,
    CMP_GEU = 3'b111
  } cmp_op_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_format_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_REL   = 2'b01,
    PC_JALR  = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    TC_NONE   = 2'b00,
    TC_OPCODE = 2'b01,
    TC_FUNCT3 = 2'b10,
    TC_SYSTEM = 2'b11
  } trap_cause_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - opcode/funct decode to ALU op, immediate format, writeback select, legality
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   funct3_i,
  input  logic         funct7_5_i,
  output alu_op_t      alu_op_o,
  output inst_format_t imm_fmt_o,
  output wb_sel_t      wb_sel_o,
  output trap_cause_t  trap_cause_o
);

  always_comb begin
    alu_op_o     = ALU_ADD;
    imm_fmt_o    = FMT_R;
    wb_sel_o     = WB_ALU;
    trap_cause_o = TC_NONE;
    case (opcode_i)
      OP_OP:       alu_op_o = alu_op_t'({funct7_5_i, funct3_i});
      OP_IMM: begin
        // IR[30] is immediate data except for the shift-right pair.
        alu_op_o  = alu_op_t'({(funct3_i == 3'b101) & funct7_5_i, funct3_i});
        imm_fmt_o = FMT_I;
      end
      OP_LOAD: begin
        imm_fmt_o = FMT_I;
        wb_sel_o  = WB_MEM;
      end
      OP_STORE:    imm_fmt_o = FMT_S;
      OP_BRANCH: begin
        imm_fmt_o = FMT_B;
        if (funct3_i == 3'b010 || funct3_i == 3'b011) trap_cause_o = TC_FUNCT3;
      end
      OP_JAL: begin
        imm_fmt_o = FMT_J;
        wb_sel_o  = WB_PC4;
      end
      OP_JALR: begin
        imm_fmt_o = FMT_I;
        wb_sel_o  = WB_PC4;
      end
      OP_LUI: begin
        imm_fmt_o = FMT_U;
        wb_sel_o  = WB_IMM;
      end
      OP_AUIPC:    imm_fmt_o = FMT_U;
      OP_MISC_MEM: imm_fmt_o = FMT_I;
      OP_SYSTEM: begin
        imm_fmt_o    = FMT_I;
        trap_cause_o = TC_SYSTEM;
      end
      default:     trap_cause_o = TC_OPCODE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencing FSM: datapath controls, memory handshake, traps, instret
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit RESET_START = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  input  logic            cmp_true_i,
  input  logic            mem_ready_i,
  output logic            ir_we_o,
  output logic            pc_we_o,
  output logic [1:0]      pc_sel_o,
  output logic            alu_src_a_o,
  output logic            alu_src_b_o,
  output logic [3:0]      alu_op_o,
  output logic [2:0]      cmp_op_o,
  output logic [2:0]      imm_fmt_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            mem_addr_sel_o,
  output logic            reg_we_o,
  output logic [1:0]      wb_sel_o,
  output logic            trap_o,
  output logic [1:0]      trap_cause_o,
  output logic [XLEN-1:0] instret_o
);

  ctrl_state_t     state_q, state_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            trap_q, trap_d;
  trap_cause_t     cause_q, cause_d;
  logic            retire;

  alu_op_t         dec_alu_op;
  inst_format_t    dec_imm_fmt;
  wb_sel_t         dec_wb_sel;
  trap_cause_t     dec_trap;

  logic is_load, is_store, is_branch, is_fence, is_op, is_auipc, is_jal, is_jalr;
  assign is_load   = (opcode_i == OP_LOAD);
  assign is_store  = (opcode_i == OP_STORE);
  assign is_branch = (opcode_i == OP_BRANCH);
  assign is_fence  = (opcode_i == OP_MISC_MEM);
  assign is_op     = (opcode_i == OP_OP);
  assign is_auipc  = (opcode_i == OP_AUIPC);
  assign is_jal    = (opcode_i == OP_JAL);
  assign is_jalr   = (opcode_i == OP_JALR);

  ctrl_decode u_decode (
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .funct7_5_i   (funct7_5_i),
    .alu_op_o     (dec_alu_op),
    .imm_fmt_o    (dec_imm_fmt),
    .wb_sel_o     (dec_wb_sel),
    .trap_cause_o (dec_trap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= TC_NONE;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE:   if (en || RESET_START) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_trap != TC_NONE) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = dec_trap;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (is_load || is_store)       state_d = ST_MEM;
        else if (is_branch || is_fence) retire = 1'b1;
        else                            state_d = ST_WRITEBACK;
      end
      ST_MEM: begin
        if (mem_ready_i) begin
          if (is_store) retire  = 1'b1;
          else          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: retire = 1'b1;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_IDLE;
    endcase
    // en is only consulted at instruction boundaries.
    if (retire) state_d = en ? ST_FETCH : ST_IDLE;
    instret_d = retire ? instret_q + XLEN'(1) : instret_q;
  end

  always_comb begin
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_sel_o       = PC_PLUS4;
    alu_src_a_o    = 1'b0;
    alu_src_b_o    = 1'b0;
    alu_op_o       = ALU_ADD;
    cmp_op_o       = 3'b000;
    imm_fmt_o      = FMT_R;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    reg_we_o       = 1'b0;
    wb_sel_o       = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ready_i;
      end
      ST_DECODE: imm_fmt_o = dec_imm_fmt;
      ST_EXECUTE, ST_MEM, ST_WRITEBACK: begin
        imm_fmt_o   = dec_imm_fmt;
        alu_op_o    = dec_alu_op;
        cmp_op_o    = funct3_i;
        alu_src_a_o = is_auipc;
        alu_src_b_o = !(is_op || is_branch);
        if (state_q == ST_EXECUTE) begin
          if (is_branch) begin
            pc_we_o  = 1'b1;
            pc_sel_o = cmp_true_i ? PC_REL : PC_PLUS4;
          end else if (is_fence) begin
            pc_we_o  = 1'b1;
          end
        end else if (state_q == ST_MEM) begin
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = is_store;
          pc_we_o        = is_store && mem_ready_i;
        end else begin
          reg_we_o = 1'b1;
          pc_we_o  = 1'b1;
          wb_sel_o = dec_wb_sel;
          pc_sel_o = is_jal ? PC_REL : (is_jalr ? PC_JALR : PC_PLUS4);
        end
      end
      default: ;
    endcase
  end

  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule
